// File: rtl/note_key_encoder_pkg.sv
// Shared constants and types for the PS/2 note key encoder: prefix bytes,
// shift scan codes, prefix FSM states and the held-key record.
package note_key_encoder_pkg;

  localparam logic [7:0] PS2_BREAK   = 8'hF0;
  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] LSHIFT_CODE = 8'h12;
  localparam logic [7:0] RSHIFT_CODE = 8'h59;

  localparam logic [3:0] NONE_CODE_DEFAULT  = 4'd15;
  localparam logic [3:0] CAP_OFFSET_DEFAULT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  typedef struct packed {
    logic       active;
    logic [2:0] idx;
  } held_key_t;

endpackage

// File: rtl/note_key_encoder_if.sv
// Byte-in / note-out bundle between the PS/2 receiver, the encoder and the
// display/tone consumers.
interface note_key_encoder_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic [3:0] value;
  logic       value_valid;
  logic       shift_held;

  modport master (
    output key_valid, key_code,
    input  value, value_valid, shift_held
  );

  modport slave (
    input  key_valid, key_code,
    output value, value_valid, shift_held
  );
endinterface

// File: rtl/note_key_encoder_keymap.sv
// Scan code to note index lookup for the home-row keys A..J (c..b).
module note_keymap (
  input  logic [7:0] key_code,
  output logic       hit,
  output logic [2:0] idx
);

  always_comb begin
    // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
    hit = 1'b1;
    idx = 3'd0;
    unique case (key_code)
      8'h1C:   idx = 3'd0;
      8'h1B:   idx = 3'd1;
      8'h23:   idx = 3'd2;
      8'h2B:   idx = 3'd3;
      8'h34:   idx = 3'd4;
      8'h33:   idx = 3'd5;
      8'h3B:   idx = 3'd6;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/note_key_encoder.sv
// Tracks PS/2 make/break/extended prefixes, shift state and the single held
// note key, and presents the registered note code with a change strobe.
module note_key_encoder
  import note_key_encoder_pkg::*;
#(
  parameter logic [3:0] CAP_OFFSET = CAP_OFFSET_DEFAULT,
  parameter logic [3:0] NONE_CODE  = NONE_CODE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  note_key_encoder_if.slave  bus
);

  prefix_state_e state_q, state_d;
  held_key_t     held_q, held_d;
  logic          lshift_q, lshift_d;
  logic          rshift_q, rshift_d;
  logic [3:0]    value_q, value_d;
  logic          value_valid_q, value_valid_d;
  logic          shift_held_q, shift_held_d;

  logic          map_hit;
  logic [2:0]    map_idx;

  note_keymap u_keymap (
    .key_code (bus.key_code),
    .hit      (map_hit),
    .idx      (map_idx)
  );

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;

    if (bus.key_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.key_code == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (bus.key_code == PS2_BREAK) begin
            state_d = ST_BRK;
          end else begin
            if (bus.key_code == LSHIFT_CODE) lshift_d = 1'b1;
            if (bus.key_code == RSHIFT_CODE) rshift_d = 1'b1;
            // Monophonic: the most recent make always takes over.
            if (map_hit) held_d = '{active: 1'b1, idx: map_idx};
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (bus.key_code == LSHIFT_CODE) lshift_d = 1'b0;
          if (bus.key_code == RSHIFT_CODE) rshift_d = 1'b0;
          if (map_hit && held_q.active && map_idx == held_q.idx) held_d.active = 1'b0;
        end
        ST_EXT:  state_d = (bus.key_code == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    shift_held_d  = lshift_d | rshift_d;
    value_d       = held_d.active
                  ? ({1'b0, held_d.idx} + (shift_held_d ? CAP_OFFSET : 4'd0))
                  : NONE_CODE;
    value_valid_d = (value_d != value_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q       <= ST_IDLE;
      held_q        <= '0;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      value_q       <= NONE_CODE;
      value_valid_q <= 1'b0;
      shift_held_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      shift_held_q  <= shift_held_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.shift_held  = shift_held_q;

endmodule

// File: tb/tb_note_key_encoder.sv
// Self-checking bench: directed scenarios plus random byte streams, compared
// cycle by cycle against a sequence-level model of the keyboard protocol.
module tb_note_key_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_key_encoder_if bus_if ();

  note_key_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bytes of the unfinished sequence plus key state.
  byte unsigned pend[$];
  bit  m_lsh, m_rsh, m_act;
  int  m_idx;
  int  exp_val = 15;
  int  exp_vv  = 0;

  byte unsigned note_codes [7] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int note_index(input byte unsigned b);
    for (int i = 0; i < 7; i++)
      if (note_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic int model_value();
    if (!m_act) return 15;
    return m_idx + ((m_lsh || m_rsh) ? 7 : 0);
  endfunction

  task automatic model_step(input bit v, input byte unsigned b, input bit r);
    int  old;
    bit  ext, brk;
    byte unsigned code;
    int  n;
    if (r) begin
      pend.delete();
      m_lsh = 0; m_rsh = 0; m_act = 0; m_idx = 0;
      exp_val = 15; exp_vv = 0;
      return;
    end
    old = exp_val;
    exp_vv = 0;
    if (!v) return;
    pend.push_back(b);
    if (pend.size() == 1 && (pend[0] == 8'hE0 || pend[0] == 8'hF0)) return;
    if (pend.size() == 2 && pend[0] == 8'hE0 && pend[1] == 8'hF0) return;
    ext  = (pend[0] == 8'hE0);
    brk  = (pend.size() > 1) && (pend[pend.size()-2] == 8'hF0);
    code = pend[pend.size()-1];
    pend.delete();
    if (!ext) begin
      n = note_index(code);
      if (brk) begin
        if (code == 8'h12) m_lsh = 0;
        if (code == 8'h59) m_rsh = 0;
        if (n >= 0 && m_act && n == m_idx) m_act = 0;
      end else begin
        if (code == 8'h12) m_lsh = 1;
        if (code == 8'h59) m_rsh = 1;
        if (n >= 0) begin m_act = 1; m_idx = n; end
      end
    end
    exp_val = model_value();
    exp_vv  = (exp_val != old) ? 1 : 0;
  endtask

  // Called at a falling edge: drive one cycle of input, then check the outputs
  // registered by the following rising edge at the next falling edge.
  task automatic cycle(input bit v, input byte unsigned b, input bit r);
    rst              = r;
    bus_if.key_valid = v;
    bus_if.key_code  = b;
    model_step(v, b, r);
    @(negedge clk);
    check("value",       int'(bus_if.value),       exp_val);
    check("value_valid", int'(bus_if.value_valid), exp_vv);
    check("shift_held",  int'(bus_if.shift_held),  (m_lsh || m_rsh) ? 1 : 0);
  endtask

  task automatic send(input byte unsigned b);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  int pulses;

  initial begin
    bus_if.key_valid = 1'b0;
    bus_if.key_code  = 8'h00;
    @(negedge clk);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("reset_value", int'(bus_if.value), 15);
    idle(2);

    // Plain make of C.
    send(8'h1C);
    check("plan_c_value", int'(bus_if.value), 0);
    check("plan_c_pulse", int'(bus_if.value_valid), 1);
    idle(1);
    send(8'hF0); send(8'h1C); idle(1);

    // Shift + D, then shift release lowers the case.
    send(8'h12); send(8'h23);
    check("plan_D_value", int'(bus_if.value), 9);
    send(8'hF0); send(8'h12);
    check("plan_d_value", int'(bus_if.value), 2);
    send(8'hF0); send(8'h23); idle(1);

    // Releasing a non-current key keeps the current one.
    send(8'h1C); send(8'h3B); send(8'hF0); send(8'h1C);
    check("plan_keep_b", int'(bus_if.value), 6);
    send(8'hF0); send(8'h3B);
    check("plan_silent", int'(bus_if.value), 15);

    // Extended make/break is ignored; FSM returns to IDLE afterwards.
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
    check("plan_ext_ignored", int'(bus_if.value), 15);
    send(8'h1B);
    check("plan_after_ext", int'(bus_if.value), 1);
    send(8'hF0); send(8'h1B); idle(1);

    // Typematic repeat: one pulse only.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h34);
      pulses += int'(bus_if.value_valid);
    end
    check("plan_typematic_pulses", pulses, 1);
    check("plan_typematic_value", int'(bus_if.value), 4);
    send(8'hF0); send(8'h34); idle(1);

    // Reset in the middle of a break sequence.
    send(8'h59); send(8'h34); send(8'hF0);
    cycle(1'b0, 8'h00, 1'b1);
    check("plan_rst_value", int'(bus_if.value), 15);
    check("plan_rst_shift", int'(bus_if.shift_held), 0);
    send(8'h33);
    check("plan_rst_make", int'(bus_if.value), 5);

    // Release of a shift that is not down.
    send(8'hF0); send(8'h59);
    check("plan_spurious_shift_rel", int'(bus_if.value), 5);
    send(8'hF0); send(8'h33); idle(1);

    // Random byte streams weighted toward protocol-relevant codes.
    for (int i = 0; i < 3000; i++) begin
      bit v, r;
      byte unsigned b;
      int sel;
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 199) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: b = note_codes[$urandom_range(0, 6)];
        3:       b = 8'h12;
        4:       b = 8'h59;
        5, 6:    b = 8'hF0;
        7:       b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      cycle(v, b, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
